hififo_pattern_engine: RTL and testbench

Parametrised traffic source/sink for the hififo PCIe FIFO path, sitting between `hififo_pcie` channel ports and host PIO writes. It generates counter or LFSR streams into a to-PC (tpc) channel, loops a from-PC (fpc) channel back, or checks fpc data against a local reference generator. It provides bounded-length bursts, a PIO-programmable seed and error/word counters for host-side bandwidth and integrity tests.

---
 rtl/hififo_pattern_pkg.sv | 30 +++
 rtl/hififo_pattern_engine_if.sv | 29 ++
 rtl/hififo_lfsr32.sv | 20 ++
 rtl/hififo_pattern_engine.sv | 153 +++++++++++++++
 tb/tb_hififo_pattern_engine.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/hififo_pattern_pkg.sv
// Shared encodings for the hififo pattern engine: modes, register map,
// LFSR polynomial and FSM states.
package hififo_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_LOOP  = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] REG_MODE   = 2'd0;
  localparam logic [1:0] REG_LENGTH = 2'd1;
  localparam logic [1:0] REG_SEED   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Galois, shift right: feed bit 0 back through the tap mask.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/hififo_pattern_engine_if.sv
// PIO, tpc, fpc and status signals of the pattern engine, bundled.
// slave = engine side, master = channel/host side.
interface hififo_pattern_engine_if #(
  parameter int WIDTH = 64
);
  logic             pio_write_valid;
  logic [12:0]      pio_address;
  logic [63:0]      pio_write_data;
  logic [WIDTH-1:0] tpc_data;
  logic             tpc_write;
  logic             tpc_ready;
  logic [WIDTH-1:0] fpc_data;
  logic             fpc_read;
  logic             fpc_empty;
  logic [31:0]      word_count;
  logic [31:0]      error_count;

  modport slave (
    input  pio_write_valid, pio_address, pio_write_data,
    input  tpc_ready, fpc_data, fpc_empty,
    output tpc_data, tpc_write, fpc_read, word_count, error_count
  );

  modport master (
    output pio_write_valid, pio_address, pio_write_data,
    output tpc_ready, fpc_data, fpc_empty,
    input  tpc_data, tpc_write, fpc_read, word_count, error_count
  );
endinterface

// File: rtl/hififo_lfsr32.sv
// 32-bit Galois LFSR with load and advance; a zero seed loads as 1 so the
// register can never lock up.
module hififo_lfsr32
  import hififo_pattern_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  always_ff @(posedge clock) begin
    if (reset)        state <= 32'd0;
    else if (load)    state <= (seed == 32'd0) ? 32'd1 : seed;
    else if (advance) state <= lfsr_next(state);
  end

endmodule

// File: rtl/hififo_pattern_engine.sv
// Counter/LFSR traffic source, fpc loopback and fpc stream checker with
// PIO-programmed mode, burst length and seed.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | stopped; no tpc writes, checker off
//   ST_RUN  | generating / looping; bounded bursts count down remaining
//   ST_DONE | bounded burst finished; checker still live, waits for R0
module hififo_pattern_engine
  import hififo_pattern_pkg::*;
#(
  parameter int         WIDTH     = 64,
  parameter logic [12:0] ADDR_BASE = 13'd16
) (
  input logic                  clock,
  input logic                  reset,
  hififo_pattern_engine_if.slave bus
);

  localparam int REPS = WIDTH / 32;

  logic [12:0] off;
  logic        wr_hit, wr_mode, wr_len, wr_seed, wr_ctrl, start, clear;
  logic        unused_pio;

  assign off     = bus.pio_address - ADDR_BASE;
  assign wr_hit  = bus.pio_write_valid && (off[12:2] == 11'd0);
  assign wr_mode = wr_hit && (off[1:0] == REG_MODE);
  assign wr_len  = wr_hit && (off[1:0] == REG_LENGTH);
  assign wr_seed = wr_hit && (off[1:0] == REG_SEED);
  assign wr_ctrl = wr_hit && (off[1:0] == REG_CTRL);
  assign start   = wr_mode && (bus.pio_write_data[1:0] != MODE_IDLE);
  assign clear   = wr_ctrl && bus.pio_write_data[1];
  assign unused_pio = ^bus.pio_write_data[63:32];

  mode_t       mode_q;
  logic [31:0] length_q, seed_q;
  logic        check_en_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q     <= MODE_IDLE;
      length_q   <= 32'd0;
      seed_q     <= 32'd0;
      check_en_q <= 1'b0;
    end else begin
      if (wr_mode) mode_q     <= mode_t'(bus.pio_write_data[1:0]);
      if (wr_len)  length_q   <= bus.pio_write_data[31:0];
      if (wr_seed) seed_q     <= bus.pio_write_data[31:0];
      if (wr_ctrl) check_en_q <= bus.pio_write_data[0];
    end
  end

  state_t           state_q, state_d;
  logic             ready_q, bounded_q, mismatch_q, tpc_write_q;
  logic [31:0]      remaining_q, word_count_q, error_count_q;
  logic [WIDTH-1:0] gen_cnt_q, ref_cnt_q, tpc_data_q, expected;
  logic [31:0]      gen_lfsr, ref_lfsr;
  logic             issue, check_active, chk_pop, fpc_read_c;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    issue        = 1'b0;
    check_active = check_en_q && (mode_q == MODE_COUNT || mode_q == MODE_LFSR)
                   && (state_q != ST_IDLE);
    chk_pop      = check_active && !bus.fpc_empty;
    if (state_q == ST_RUN && !wr_mode) begin
      // Loopback reacts to the live ready; generators use the sampled one.
      if (mode_q == MODE_LOOP) issue = bus.tpc_ready && !bus.fpc_empty;
      else                     issue = ready_q;
    end
    fpc_read_c = (mode_q == MODE_LOOP) ? issue : chk_pop;
    if (issue && bounded_q && remaining_q == 32'd1) state_d = ST_DONE;
    if (wr_mode) state_d = start ? ST_RUN : ST_IDLE;
  end

  assign expected = (mode_q == MODE_COUNT) ? ref_cnt_q : {REPS{ref_lfsr}};

  hififo_lfsr32 u_gen_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (start),
    .seed    (seed_q),
    .advance (issue && mode_q == MODE_LFSR),
    .state   (gen_lfsr)
  );

  hififo_lfsr32 u_ref_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (start),
    .seed    (seed_q),
    .advance (chk_pop && mode_q == MODE_LFSR),
    .state   (ref_lfsr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q       <= 1'b0;
      tpc_write_q   <= 1'b0;
      tpc_data_q    <= '0;
      remaining_q   <= 32'd0;
      bounded_q     <= 1'b0;
      gen_cnt_q     <= '0;
      ref_cnt_q     <= '0;
      mismatch_q    <= 1'b0;
      word_count_q  <= 32'd0;
      error_count_q <= 32'd0;
    end else begin
      ready_q     <= bus.tpc_ready;
      tpc_write_q <= issue;
      mismatch_q  <= chk_pop && !wr_mode && (bus.fpc_data != expected);
      if (start) begin
        remaining_q <= length_q;
        bounded_q   <= (length_q != 32'd0);
        gen_cnt_q   <= WIDTH'(seed_q);
        ref_cnt_q   <= WIDTH'(seed_q);
      end else begin
        if (issue) begin
          if (bounded_q) remaining_q <= remaining_q - 32'd1;
          case (mode_q)
            MODE_COUNT: begin
              tpc_data_q <= gen_cnt_q;
              gen_cnt_q  <= gen_cnt_q + WIDTH'(1);
            end
            MODE_LFSR: tpc_data_q <= {REPS{gen_lfsr}};
            MODE_LOOP: tpc_data_q <= bus.fpc_data;
            default:   tpc_data_q <= tpc_data_q;
          endcase
        end
        if (chk_pop) ref_cnt_q <= ref_cnt_q + WIDTH'(1);
      end
      // Clear beats a coincident increment on both counters.
      if (clear)      word_count_q <= 32'd0;
      else if (issue) word_count_q <= word_count_q + 32'd1;
      if (clear) error_count_q <= 32'd0;
      else if (mismatch_q && error_count_q != 32'hFFFF_FFFF)
        error_count_q <= error_count_q + 32'd1;
    end
  end

  assign bus.tpc_data    = tpc_data_q;
  assign bus.tpc_write   = tpc_write_q;
  assign bus.fpc_read    = fpc_read_c;
  assign bus.word_count  = word_count_q;
  assign bus.error_count = error_count_q;

endmodule

// File: tb/tb_hififo_pattern_engine.sv
// Directed bench for hififo_pattern_engine: one task per feature, each with
// hand-computed expectations.
module tb_hififo_pattern_engine;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_wc;

  hififo_pattern_engine_if #(.WIDTH(64)) bus ();

  hififo_pattern_engine #(.WIDTH(64), .ADDR_BASE(13'd16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pio(input logic [12:0] addr, input logic [63:0] data);
    bus.pio_write_valid = 1'b1;
    bus.pio_address     = addr;
    bus.pio_write_data  = data;
    tick();
    bus.pio_write_valid = 1'b0;
  endtask

  task automatic wreg(input int r, input logic [63:0] data);
    pio(13'(16 + r), data);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.fpc_empty = 1'b0;
    tick();
    tick();
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL reset_tpc_write got %b want 0", bus.tpc_write); end
    checks++; if (bus.tpc_data !== 64'd0) begin errors++; $display("FAIL reset_tpc_data got %h want 0", bus.tpc_data); end
    checks++; if (bus.word_count !== 32'd0) begin errors++; $display("FAIL reset_word_count got %0d want 0", bus.word_count); end
    checks++; if (bus.error_count !== 32'd0) begin errors++; $display("FAIL reset_error_count got %0d want 0", bus.error_count); end
    checks++; if (bus.fpc_read !== 1'b0) begin errors++; $display("FAIL reset_fpc_read got %b want 0", bus.fpc_read); end
    reset = 1'b0;
    bus.fpc_empty = 1'b1;
    tick();
    exp_wc = 32'd0;
  endtask

  task automatic test_count();
    bus.tpc_ready = 1'b1;
    wreg(1, 64'd4);
    wreg(2, 64'd5);
    wreg(3, 64'd0);
    wreg(0, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.tpc_write !== 1'b1) begin errors++; $display("FAIL count_write[%0d] got %b want 1", i, bus.tpc_write); end
      checks++; if (bus.tpc_data !== 64'(5 + i)) begin errors++; $display("FAIL count_data[%0d] got %0d want %0d", i, bus.tpc_data, 5 + i); end
    end
    tick();
    exp_wc += 32'd4;
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL count_done_write got %b want 0", bus.tpc_write); end
    checks++; if (bus.word_count !== exp_wc) begin errors++; $display("FAIL count_word_count got %0d want %0d", bus.word_count, exp_wc); end
  endtask

  task automatic test_lfsr();
    logic [31:0] gold [3];
    gold[0] = 32'h0000_0001;
    gold[1] = 32'h8020_0003;
    gold[2] = 32'hC030_0002;
    wreg(2, 64'd0);
    wreg(1, 64'd3);
    wreg(0, 64'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.tpc_write !== 1'b1) begin errors++; $display("FAIL lfsr_write[%0d] got %b want 1", i, bus.tpc_write); end
      checks++; if (bus.tpc_data !== {gold[i], gold[i]}) begin errors++; $display("FAIL lfsr_data[%0d] got %h want %h", i, bus.tpc_data, {gold[i], gold[i]}); end
    end
    tick();
    exp_wc += 32'd3;
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL lfsr_done_write got %b want 0", bus.tpc_write); end
    checks++; if (bus.word_count !== exp_wc) begin errors++; $display("FAIL lfsr_word_count got %0d want %0d", bus.word_count, exp_wc); end
  endtask

  task automatic test_toggle();
    logic [7:0]  pat;
    logic [63:0] exp_cnt;
    logic        exp_wr;
    pat = 8'b0100_1101;
    exp_cnt = 64'd10;
    bus.tpc_ready = 1'b0;
    wreg(1, 64'd0);
    wreg(2, 64'd10);
    wreg(0, 64'd1);
    for (int k = 0; k <= 8; k++) begin
      bus.tpc_ready = (k < 8) ? pat[k] : 1'b0;
      exp_wr = (k == 0) ? 1'b0 : pat[k-1];
      tick();
      checks++; if (bus.tpc_write !== exp_wr) begin errors++; $display("FAIL toggle_write[%0d] got %b want %b", k, bus.tpc_write, exp_wr); end
      if (exp_wr) begin
        checks++; if (bus.tpc_data !== exp_cnt) begin errors++; $display("FAIL toggle_data[%0d] got %0d want %0d", k, bus.tpc_data, exp_cnt); end
        exp_cnt++;
      end
    end
    wreg(0, 64'd0);
    exp_wc += 32'd4;
    checks++; if (bus.word_count !== exp_wc) begin errors++; $display("FAIL toggle_word_count got %0d want %0d", bus.word_count, exp_wc); end
  endtask

  task automatic test_loop();
    logic [63:0] vals [3];
    vals[0] = 64'hDEAD_BEEF_0000_0001;
    vals[1] = 64'h0123_4567_89AB_CDEF;
    vals[2] = 64'hFFFF_0000_A5A5_5A5A;
    bus.tpc_ready = 1'b1;
    bus.fpc_empty = 1'b1;
    wreg(1, 64'd0);
    wreg(0, 64'd2);
    for (int i = 0; i < 3; i++) begin
      bus.fpc_data  = vals[i];
      bus.fpc_empty = 1'b0;
      #1;
      checks++; if (bus.fpc_read !== 1'b1) begin errors++; $display("FAIL loop_fpc_read[%0d] got %b want 1", i, bus.fpc_read); end
      tick();
      checks++; if (bus.tpc_write !== 1'b1) begin errors++; $display("FAIL loop_write[%0d] got %b want 1", i, bus.tpc_write); end
      checks++; if (bus.tpc_data !== vals[i]) begin errors++; $display("FAIL loop_data[%0d] got %h want %h", i, bus.tpc_data, vals[i]); end
    end
    bus.fpc_empty = 1'b1;
    tick();
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL loop_idle_write got %b want 0", bus.tpc_write); end
    wreg(0, 64'd0);
    exp_wc += 32'd3;
    checks++; if (bus.word_count !== exp_wc) begin errors++; $display("FAIL loop_word_count got %0d want %0d", bus.word_count, exp_wc); end
  endtask

  task automatic test_checker();
    logic [63:0] stream [4];
    stream[0] = 64'd0;
    stream[1] = 64'd1;
    stream[2] = 64'd9;
    stream[3] = 64'd3;
    bus.tpc_ready = 1'b0;
    bus.fpc_empty = 1'b1;
    wreg(2, 64'd0);
    wreg(3, 64'd1);
    wreg(0, 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.fpc_data  = stream[i];
      bus.fpc_empty = 1'b0;
      #1;
      checks++; if (bus.fpc_read !== 1'b1) begin errors++; $display("FAIL chk_fpc_read[%0d] got %b want 1", i, bus.fpc_read); end
      tick();
    end
    bus.fpc_empty = 1'b1;
    tick();
    checks++; if (bus.error_count !== 32'd1) begin errors++; $display("FAIL chk_error_count got %0d want 1", bus.error_count); end
    // Next reference value is 4; 99 mismatches, and the clear lands on the increment edge.
    bus.fpc_data  = 64'd99;
    bus.fpc_empty = 1'b0;
    tick();
    bus.fpc_empty = 1'b1;
    wreg(3, 64'd3);
    checks++; if (bus.error_count !== 32'd0) begin errors++; $display("FAIL chk_clear_collision got %0d want 0", bus.error_count); end
    checks++; if (bus.word_count !== 32'd0) begin errors++; $display("FAIL chk_clear_word_count got %0d want 0", bus.word_count); end
    tick();
    checks++; if (bus.error_count !== 32'd0) begin errors++; $display("FAIL chk_after_clear got %0d want 0", bus.error_count); end
    wreg(3, 64'd0);
    bus.fpc_empty = 1'b0;
    #1;
    checks++; if (bus.fpc_read !== 1'b0) begin errors++; $display("FAIL chk_disabled_fpc_read got %b want 0", bus.fpc_read); end
    bus.fpc_empty = 1'b1;
    wreg(0, 64'd0);
    exp_wc = 32'd0;
  endtask

  task automatic test_abort();
    wreg(1, 64'd0);
    wreg(2, 64'd100);
    bus.tpc_ready = 1'b1;
    wreg(0, 64'd1);
    tick();
    tick();
    checks++; if (bus.tpc_write !== 1'b1) begin errors++; $display("FAIL abort_running got %b want 1", bus.tpc_write); end
    checks++; if (bus.tpc_data !== 64'd101) begin errors++; $display("FAIL abort_data got %0d want 101", bus.tpc_data); end
    wreg(0, 64'd0);
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL abort_mode0_write got %b want 0", bus.tpc_write); end
    tick();
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL abort_idle_write got %b want 0", bus.tpc_write); end
    wreg(0, 64'd1);
    tick();
    tick();
    checks++; if (bus.tpc_write !== 1'b1) begin errors++; $display("FAIL abort_restart got %b want 1", bus.tpc_write); end
    reset = 1'b1;
    tick();
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL abort_reset_write got %b want 0", bus.tpc_write); end
    checks++; if (bus.tpc_data !== 64'd0) begin errors++; $display("FAIL abort_reset_data got %h want 0", bus.tpc_data); end
    checks++; if (bus.word_count !== 32'd0) begin errors++; $display("FAIL abort_reset_word_count got %0d want 0", bus.word_count); end
    checks++; if (bus.error_count !== 32'd0) begin errors++; $display("FAIL abort_reset_error_count got %0d want 0", bus.error_count); end
    reset = 1'b0;
    pio(13'd20, 64'd1);
    pio(13'd15, 64'd1);
    tick();
    tick();
    checks++; if (bus.tpc_write !== 1'b0) begin errors++; $display("FAIL unmapped_write got %b want 0", bus.tpc_write); end
    bus.fpc_empty = 1'b0;
    #1;
    checks++; if (bus.fpc_read !== 1'b0) begin errors++; $display("FAIL post_reset_fpc_read got %b want 0", bus.fpc_read); end
    bus.fpc_empty = 1'b1;
  endtask

  initial begin
    bus.pio_write_valid = 1'b0;
    bus.pio_address     = 13'd0;
    bus.pio_write_data  = 64'd0;
    bus.tpc_ready       = 1'b0;
    bus.fpc_data        = 64'd0;
    bus.fpc_empty       = 1'b1;
    exp_wc              = 32'd0;
    test_reset();
    test_count();
    test_lfsr();
    test_toggle();
    test_loop();
    test_checker();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
